alu_control_seq: RTL and testbench

//  Registered, handshaked successor to the combinational ALU-control decoder of the RV32 core.

---
 rtl/aluc_pkg.sv | 81 ++++++++
 rtl/alu_control_seq_if.sv | 29 ++
 rtl/alu_control_dec.sv | 65 ++++++
 rtl/alu_control_seq.sv | 128 ++++++++++++
 tb/tb_alu_control_seq.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aluc_pkg.sv
// Shared types and constants for the ALU-control sequencer: ALU operation
// codes, the ID-stage aluop classes, FSM state encodings and the func7
// patterns recognised by the decoder.
package aluc_pkg;

  typedef enum logic [4:0] {
    ALUC_ADD    = 5'd0,
    ALUC_SUB    = 5'd1,
    ALUC_SLL    = 5'd2,
    ALUC_SLT    = 5'd3,
    ALUC_SLTU   = 5'd4,
    ALUC_XOR    = 5'd5,
    ALUC_SRL    = 5'd6,
    ALUC_SRA    = 5'd7,
    ALUC_OR     = 5'd8,
    ALUC_AND    = 5'd9,
    ALUC_BEQ    = 5'd10,
    ALUC_BNE    = 5'd11,
    ALUC_BLT    = 5'd12,
    ALUC_BGE    = 5'd13,
    ALUC_BLTU   = 5'd14,
    ALUC_BGEU   = 5'd15,
    ALUC_PASS_B = 5'd16,
    ALUC_JAL    = 5'd17,
    ALUC_MUL    = 5'd24,
    ALUC_MULH   = 5'd25,
    ALUC_MULHSU = 5'd26,
    ALUC_MULHU  = 5'd27,
    ALUC_DIV    = 5'd28,
    ALUC_DIVU   = 5'd29,
    ALUC_REM    = 5'd30,
    ALUC_REMU   = 5'd31
  } aluc_e;

  typedef enum logic [2:0] {
    AOP_R     = 3'b000,
    AOP_I     = 3'b001,
    AOP_LDST  = 3'b010,
    AOP_BR    = 3'b011,
    AOP_LUI   = 3'b100,
    AOP_AUIPC = 3'b101,
    AOP_JAL   = 3'b110,
    AOP_RSVD  = 3'b111
  } aluop_e;

  // FSM state encodings kept as plain constants for legacy tooling.
  typedef logic [1:0] state_e;
  localparam state_e ST_IDLE  = 2'd0;
  localparam state_e ST_COUNT = 2'd1;
  localparam state_e ST_HOLD  = 2'd2;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef struct packed {
    aluc_e aluc;
    logic  illegal;
    logic  multi;
  } dec_t;

  // func3 -> base integer op, shared by the R and I decode paths.
  function automatic aluc_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALUC_ADD;
      3'b001:  return ALUC_SLL;
      3'b010:  return ALUC_SLT;
      3'b011:  return ALUC_SLTU;
      3'b100:  return ALUC_XOR;
      3'b101:  return ALUC_SRL;
      3'b110:  return ALUC_OR;
      default: return ALUC_AND;
    endcase
  endfunction

  // DIV/DIVU/REM/REMU occupy codes 28..31; MUL* occupy 24..27.
  function automatic logic is_div_op(input aluc_e op);
    return (op[4:3] == 2'b11) && op[2];
  endfunction

endpackage

// File: rtl/alu_control_seq_if.sv
// Handshake bundle between ID (issue side) and EX (result side) of the
// ALU-control sequencer. Signal names are from the sequencer's viewpoint;
// the sequencer uses the slave modport, the driver of ID/EX uses master.
interface alu_control_seq_if #(
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned ALUC_W  = 5
);
  logic               valid_i;
  logic               ready_o;
  logic [ALUOP_W-1:0] aluop_i;
  logic [2:0]         func3_i;
  logic [6:0]         func7_i;
  logic               valid_o;
  logic               ready_i;
  logic [ALUC_W-1:0]  aluc_o;
  logic               multi_o;
  logic               illegal_o;
  logic               busy_o;

  modport slave (
    input  valid_i, aluop_i, func3_i, func7_i, ready_i,
    output ready_o, valid_o, aluc_o, multi_o, illegal_o, busy_o
  );

  modport master (
    output valid_i, aluop_i, func3_i, func7_i, ready_i,
    input  ready_o, valid_o, aluc_o, multi_o, illegal_o, busy_o
  );
endinterface

// File: rtl/alu_control_dec.sv
// Pure combinational decode of {aluop, func3, func7} into an ALU operation
// code plus illegal/multi-cycle flags. Illegal encodings always yield ADD.
// Optional macro ALU_CTRL_MEXT_EN enables decoding of the M extension
// (func7 = 0000001 R-type); without it those encodings are illegal.
// Only aluop_i[2:0] carries meaning; ALUOP_W is expected to be 3.
module alu_control_dec
  import aluc_pkg::*;
#(
  parameter int unsigned ALUOP_W = 3
) (
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [2:0]         func3_i,
  input  logic [6:0]         func7_i,
  output dec_t               dec_o
);

  // Decode table; every path starts from the ADD/legal/single-cycle default.
  always_comb begin
    // NOTE: assigning a default to every output first means no path can leave
    // a signal unassigned, so no latch is inferred.
    dec_o = '{aluc: ALUC_ADD, illegal: 1'b0, multi: 1'b0};
    case (aluop_e'(aluop_i[2:0]))
      AOP_R: begin
        if (func7_i == F7_BASE) begin
          dec_o.aluc = base_op(func3_i);
        end else if (func7_i == F7_ALT && func3_i == 3'b000) begin
          dec_o.aluc = ALUC_SUB;
        end else if (func7_i == F7_ALT && func3_i == 3'b101) begin
          dec_o.aluc = ALUC_SRA;
`ifdef ALU_CTRL_MEXT_EN
        end else if (func7_i == F7_MEXT) begin
          dec_o.aluc  = aluc_e'({2'b11, func3_i});
          dec_o.multi = 1'b1;
`endif
        end else begin
          dec_o.illegal = 1'b1;
        end
      end
      AOP_I: begin
        // Immediate forms ignore func7 except to pick arithmetic right shift.
        if (func3_i == 3'b101) begin
          dec_o.aluc = func7_i[5] ? ALUC_SRA : ALUC_SRL;
        end else begin
          dec_o.aluc = base_op(func3_i);
        end
      end
      AOP_LDST, AOP_AUIPC: dec_o.aluc = ALUC_ADD;
      AOP_BR: begin
        case (func3_i)
          3'b000:  dec_o.aluc = ALUC_BEQ;
          3'b001:  dec_o.aluc = ALUC_BNE;
          3'b100:  dec_o.aluc = ALUC_BLT;
          3'b101:  dec_o.aluc = ALUC_BGE;
          3'b110:  dec_o.aluc = ALUC_BLTU;
          3'b111:  dec_o.aluc = ALUC_BGEU;
          default: dec_o.illegal = 1'b1;
        endcase
      end
      AOP_LUI: dec_o.aluc = ALUC_PASS_B;
      AOP_JAL: dec_o.aluc = ALUC_JAL;
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// Registered, handshaked ALU-control stage between ID and EX. Single-cycle
// ops appear on the output one cycle after acceptance; M-extension ops hold
// the issue side in COUNT for MUL_LAT/DIV_LAT cycles, then sit in HOLD until
// EX takes them.
// Optional macro ALU_CTRL_MEXT_EN enables the M extension; when undefined,
// COUNT/HOLD are unreachable and busy_o/multi_o are tied low.
module alu_control_seq
  import aluc_pkg::*;
#(
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned ALUC_W  = 5,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 33
) (
  input logic               clk_i,
  input logic               rst_ni,
  alu_control_seq_if.slave  bus
);

`ifdef ALU_CTRL_MEXT_EN
  localparam bit MEXT_EN = 1'b1;
`else
  localparam bit MEXT_EN = 1'b0;
`endif

  localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  dec_t             dec;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  aluc_e            aluc_q, aluc_d;
  aluc_e            pend_q, pend_d;
  logic             multi_q, multi_d;
  logic             illegal_q, illegal_d;
  logic             ready;

  alu_control_dec #(.ALUOP_W(ALUOP_W)) u_dec (
    .aluop_i (bus.aluop_i),
    .func3_i (bus.func3_i),
    .func7_i (bus.func7_i),
    .dec_o   (dec)
  );

  // Next-state logic: accept/drain in IDLE, latency countdown, result hold.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    aluc_d    = aluc_q;
    pend_d    = pend_q;
    multi_d   = multi_q;
    illegal_d = illegal_q;
    ready     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Free to accept when the output slot is empty or draining this cycle.
        ready = !valid_q || bus.ready_i;
        if (bus.valid_i && ready) begin
          if (dec.multi) begin
            state_d = ST_COUNT;
            cnt_d   = is_div_op(dec.aluc) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
            pend_d  = dec.aluc;
            valid_d = 1'b0;
          end else begin
            aluc_d    = dec.aluc;
            illegal_d = dec.illegal;
            multi_d   = 1'b0;
            valid_d   = 1'b1;
          end
        end else if (bus.ready_i) begin
          valid_d = 1'b0;
        end
      end
      ST_COUNT: begin
        if (cnt_q == '0) begin
          state_d   = ST_HOLD;
          aluc_d    = pend_q;
          multi_d   = 1'b1;
          illegal_d = 1'b0;
          valid_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (bus.ready_i) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          multi_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight op.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      aluc_q    <= ALUC_ADD;
      pend_q    <= ALUC_ADD;
      multi_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      aluc_q    <= aluc_d;
      pend_q    <= pend_d;
      multi_q   <= multi_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.ready_o   = ready;
  assign bus.valid_o   = valid_q;
  assign bus.aluc_o    = ALUC_W'(aluc_q);
  assign bus.illegal_o = illegal_q;
  assign bus.multi_o   = MEXT_EN && multi_q;
  assign bus.busy_o    = MEXT_EN && (state_q == ST_COUNT);

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: a table of single-cycle decode
// vectors streamed back-to-back, plus hand-written sequences for reset,
// backpressure, asynchronous reset and (with ALU_CTRL_MEXT_EN) M-ext timing.
module tb_alu_control_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_control_seq_if #(.ALUOP_W(3), .ALUC_W(5)) bus ();

  alu_control_seq #(
    .ALUOP_W (3),
    .ALUC_W  (5),
    .MUL_LAT (3),
    .DIV_LAT (33)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [2:0] aluop;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] aluc;
    logic       ill;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [4:0] aluc, input logic ill);
    vec_t v;
    v.aluop = op; v.f3 = f3; v.f7 = f7; v.aluc = aluc; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic rdy);
    bus.valid_i = v;
    bus.aluop_i = op;
    bus.func3_i = f3;
    bus.func7_i = f7;
    bus.ready_i = rdy;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // R-type
    add(3'b000, 3'b000, 7'b0000000, 5'd0,  1'b0);
    add(3'b000, 3'b000, 7'b0100000, 5'd1,  1'b0);
    add(3'b000, 3'b001, 7'b0000000, 5'd2,  1'b0);
    add(3'b000, 3'b010, 7'b0000000, 5'd3,  1'b0);
    add(3'b000, 3'b011, 7'b0000000, 5'd4,  1'b0);
    add(3'b000, 3'b100, 7'b0000000, 5'd5,  1'b0);
    add(3'b000, 3'b101, 7'b0000000, 5'd6,  1'b0);
    add(3'b000, 3'b101, 7'b0100000, 5'd7,  1'b0);
    add(3'b000, 3'b110, 7'b0000000, 5'd8,  1'b0);
    add(3'b000, 3'b111, 7'b0000000, 5'd9,  1'b0);
    add(3'b000, 3'b001, 7'b0100000, 5'd0,  1'b1);
    add(3'b000, 3'b000, 7'b0000010, 5'd0,  1'b1);
    // I-type
    add(3'b001, 3'b000, 7'b0100000, 5'd0,  1'b0);
    add(3'b001, 3'b101, 7'b0100000, 5'd7,  1'b0);
    add(3'b001, 3'b101, 7'b0000000, 5'd6,  1'b0);
    add(3'b001, 3'b010, 7'b1111111, 5'd3,  1'b0);
    add(3'b001, 3'b111, 7'b0000000, 5'd9,  1'b0);
    // ld/st, branches, LUI, AUIPC, JAL, reserved
    add(3'b010, 3'b011, 7'b0000000, 5'd0,  1'b0);
    add(3'b011, 3'b000, 7'b0000000, 5'd10, 1'b0);
    add(3'b011, 3'b001, 7'b0000000, 5'd11, 1'b0);
    add(3'b011, 3'b100, 7'b0000000, 5'd12, 1'b0);
    add(3'b011, 3'b101, 7'b0000000, 5'd13, 1'b0);
    add(3'b011, 3'b110, 7'b0000000, 5'd14, 1'b0);
    add(3'b011, 3'b111, 7'b0000000, 5'd15, 1'b0);
    add(3'b011, 3'b010, 7'b0000000, 5'd0,  1'b1);
    add(3'b011, 3'b011, 7'b0000000, 5'd0,  1'b1);
    add(3'b100, 3'b000, 7'b0000000, 5'd16, 1'b0);
    add(3'b101, 3'b000, 7'b0000000, 5'd0,  1'b0);
    add(3'b110, 3'b000, 7'b0000000, 5'd17, 1'b0);
    add(3'b111, 3'b000, 7'b0000000, 5'd0,  1'b1);
`ifndef ALU_CTRL_MEXT_EN
    // Without the M extension these are plain single-cycle illegal ops.
    add(3'b000, 3'b100, 7'b0000001, 5'd0,  1'b1);
    add(3'b000, 3'b000, 7'b0000001, 5'd0,  1'b1);
`endif

    // ---- reset state ----
    drive(1'b0, 3'b000, 3'b000, 7'b0, 1'b1);
    #12;
    check("rst valid_o",   32'(bus.valid_o),   32'd0);
    check("rst aluc_o",    32'(bus.aluc_o),    32'd0);
    check("rst multi_o",   32'(bus.multi_o),   32'd0);
    check("rst illegal_o", 32'(bus.illegal_o), 32'd0);
    check("rst busy_o",    32'(bus.busy_o),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post-rst ready_o", 32'(bus.ready_o), 32'd1);
    check("post-rst valid_o", 32'(bus.valid_o), 32'd0);

    // ---- table, streamed back-to-back with ready_i=1 ----
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].aluop, vecs[i].f3, vecs[i].f7, 1'b1);
      #1;
      check($sformatf("vec%0d ready_o", i), 32'(bus.ready_o), 32'd1);
      tick();
      check($sformatf("vec%0d valid_o", i),   32'(bus.valid_o),   32'd1);
      check($sformatf("vec%0d aluc_o", i),    32'(bus.aluc_o),    32'(vecs[i].aluc));
      check($sformatf("vec%0d illegal_o", i), 32'(bus.illegal_o), 32'(vecs[i].ill));
      check($sformatf("vec%0d multi_o", i),   32'(bus.multi_o),   32'd0);
      check($sformatf("vec%0d busy_o", i),    32'(bus.busy_o),    32'd0);
    end
    drive(1'b0, 3'b000, 3'b000, 7'b0, 1'b1);
    tick();
    check("drain valid_o", 32'(bus.valid_o), 32'd0);

    // ---- backpressure: I-type SRA held while EX stalls ----
    drive(1'b1, 3'b001, 3'b101, 7'b0100000, 1'b0);
    #1;
    check("bp accept ready_o", 32'(bus.ready_o), 32'd1);
    tick();
    check("bp valid_o", 32'(bus.valid_o), 32'd1);
    check("bp aluc_o",  32'(bus.aluc_o),  32'd7);
    drive(1'b1, 3'b011, 3'b000, 7'b0, 1'b0);  // BEQ waiting behind the stall
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("bp%0d ready_o", c), 32'(bus.ready_o), 32'd0);
      tick();
      check($sformatf("bp%0d valid_o", c), 32'(bus.valid_o), 32'd1);
      check($sformatf("bp%0d aluc_o", c),  32'(bus.aluc_o),  32'd7);
    end
    // Release: drain SRA and load BEQ in the same cycle.
    bus.ready_i = 1'b1;
    #1;
    check("bp release ready_o", 32'(bus.ready_o), 32'd1);
    tick();
    check("bp next valid_o", 32'(bus.valid_o), 32'd1);
    check("bp next aluc_o",  32'(bus.aluc_o),  32'd10);

    // ---- async reset while a result is stalled ----
    drive(1'b0, 3'b000, 3'b000, 7'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst valid_o", 32'(bus.valid_o), 32'd0);
    check("arst aluc_o",  32'(bus.aluc_o),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst after ready_o", 32'(bus.ready_o), 32'd1);

`ifdef ALU_CTRL_MEXT_EN
    begin
      int busy_cnt;
      bit done;
      // ---- DIV: 33 busy cycles, then held result ----
      drive(1'b1, 3'b000, 3'b100, 7'b0000001, 1'b1);
      tick();
      drive(1'b0, 3'b000, 3'b000, 7'b0, 1'b0);
      #1;
      check("div ready_o in count", 32'(bus.ready_o), 32'd0);
      busy_cnt = 0;
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
        if (bus.valid_o) done = 1'b1;
        else begin
          if (bus.busy_o) busy_cnt++;
          tick();
        end
      end
      check("div done in budget", 32'(done),     32'd1);
      check("div busy cycles",    32'(busy_cnt), 32'd33);
      check("div aluc_o",   32'(bus.aluc_o),    32'd28);
      check("div multi_o",  32'(bus.multi_o),   32'd1);
      check("div busy_o",   32'(bus.busy_o),    32'd0);
      check("div illegal",  32'(bus.illegal_o), 32'd0);
      tick();
      check("div hold valid_o", 32'(bus.valid_o), 32'd1);
      check("div hold aluc_o",  32'(bus.aluc_o),  32'd28);
      check("div hold ready_o", 32'(bus.ready_o), 32'd0);
      bus.ready_i = 1'b1;
      tick();
      check("div taken valid_o", 32'(bus.valid_o), 32'd0);
      check("div taken ready_o", 32'(bus.ready_o), 32'd1);

      // ---- MULHU with MUL_LAT=3 ----
      drive(1'b1, 3'b000, 3'b011, 7'b0000001, 1'b1);
      tick();
      drive(1'b0, 3'b000, 3'b000, 7'b0, 1'b1);
      busy_cnt = 0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        if (bus.valid_o) done = 1'b1;
        else begin
          if (bus.busy_o) busy_cnt++;
          tick();
        end
      end
      check("mul busy cycles", 32'(busy_cnt),   32'd3);
      check("mul aluc_o",      32'(bus.aluc_o), 32'd27);
      tick();
      check("mul taken valid_o", 32'(bus.valid_o), 32'd0);

      // ---- reset five cycles into a DIV ----
      drive(1'b1, 3'b000, 3'b100, 7'b0000001, 1'b1);
      tick();
      drive(1'b0, 3'b000, 3'b000, 7'b0, 1'b1);
      for (int c = 0; c < 5; c++) tick();
      check("cnt busy before rst", 32'(bus.busy_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("cnt rst valid_o", 32'(bus.valid_o), 32'd0);
      check("cnt rst busy_o",  32'(bus.busy_o),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("cnt rst ready_o", 32'(bus.ready_o), 32'd1);
      for (int c = 0; c < 40; c++) tick();
      check("cnt rst op dropped", 32'(bus.valid_o), 32'd0);
    end
`else
    // ---- M encoding without the extension: illegal after one cycle ----
    drive(1'b1, 3'b000, 3'b100, 7'b0000001, 1'b1);
    tick();
    drive(1'b0, 3'b000, 3'b000, 7'b0, 1'b1);
    check("nomext valid_o",   32'(bus.valid_o),   32'd1);
    check("nomext illegal_o", 32'(bus.illegal_o), 32'd1);
    check("nomext aluc_o",    32'(bus.aluc_o),    32'd0);
    check("nomext busy_o",    32'(bus.busy_o),    32'd0);
    #1;
    check("nomext ready_o",   32'(bus.ready_o),   32'd1);
    tick();
    check("nomext drained",   32'(bus.valid_o),   32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
